// File: rtl/eth_mii_tx_scheduler.sv
// eth_mii_tx_scheduler: per-frame round-robin share of one MII TX port between
// NUM_REQ byte-stream sources. Each granted frame is sent as preamble, SFD,
// data nibbles (low nibble first) and is followed by an inter-frame gap.
module eth_mii_tx_scheduler #(
   parameter int NUM_REQ     = 4,
   parameter int IFG_NIBBLES = 24,
   parameter int MAX_BYTES   = 1522
) (
   input  logic                       eth_mac_clock,
   input  logic                       eth_mac_rstn,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [8*NUM_REQ-1:0]       req_data,
   input  logic [NUM_REQ-1:0]         req_last,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic [3:0]                 eth_mii_txd,
   output logic                       eth_mii_tx_en,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       busy,
   output logic                       tx_abort
);

   localparam int          GW       = $clog2(NUM_REQ);
   localparam int          IW       = (IFG_NIBBLES > 1) ? $clog2(IFG_NIBBLES) : 1;
   localparam int unsigned NR       = NUM_REQ;
   localparam logic [GW-1:0] PTR_INIT = GW'(NUM_REQ - 1);
   localparam logic [15:0] MAX_CNT  = 16'(MAX_BYTES);
   localparam logic [IW-1:0] IFG_LAST = IW'(IFG_NIBBLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_SFD,
      S_DATA,
      S_IFG
   } state_t;

   state_t        state;
   logic [GW-1:0] rr_ptr;
   logic [3:0]    pre_cnt;
   logic [IW-1:0] ifg_cnt;
   logic          phase;
   logic [7:0]    byte_reg;
   logic          byte_last;
   logic [15:0]   byte_cnt;

   logic          any_valid;
   logic          found;
   logic [GW-1:0] pick;
   int unsigned   idx;
   logic          cur_valid;
   logic          cur_last;
   logic [7:0]    cur_data;
   logic          byte_room;

   assign any_valid = |req_valid;
   assign cur_valid = req_valid[grant_id];
   assign cur_last  = req_last[grant_id];
   assign cur_data  = req_data[{grant_id, 3'b000} +: 8];
   assign byte_room = (byte_cnt < MAX_CNT);
   assign busy      = (state != S_IDLE);

   // Round-robin search: first valid source after rr_ptr, wrapping.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      idx   = 0;
      for (int unsigned i = 1; i <= NR; i++) begin
         idx = (32'(rr_ptr) + i) % NR;
         if (!found && req_valid[GW'(idx)]) begin
            found = 1'b1;
            pick  = GW'(idx);
         end
      end
   end

   // Byte handshake to the granted source; gated by the byte budget so an
   // over-length byte is never accepted (overrun leaves it in the source).
   always_comb begin
      req_ready = '0;
      if (state == S_SFD ||
          (state == S_DATA && phase && !byte_last && byte_room))
         req_ready[grant_id] = 1'b1;
   end

   // Frame sequencer with registered MII pins and abort pulse.
   always_ff @(posedge eth_mac_clock or negedge eth_mac_rstn) begin
      if (!eth_mac_rstn) begin
         state         <= S_IDLE;
         rr_ptr        <= PTR_INIT;
         grant_id      <= '0;
         pre_cnt       <= '0;
         ifg_cnt       <= '0;
         phase         <= 1'b0;
         byte_reg      <= '0;
         byte_last     <= 1'b0;
         byte_cnt      <= '0;
         eth_mii_txd   <= '0;
         eth_mii_tx_en <= 1'b0;
         tx_abort      <= 1'b0;
      end else begin
         tx_abort <= 1'b0;
         case (state)
            S_IDLE: begin
               eth_mii_txd   <= '0;
               eth_mii_tx_en <= 1'b0;
               if (any_valid && found) begin
                  grant_id <= pick;
                  rr_ptr   <= pick;
                  pre_cnt  <= '0;
                  state    <= S_PRE;
               end
            end
            S_PRE: begin
               eth_mii_txd   <= 4'h5;
               eth_mii_tx_en <= 1'b1;
               if (pre_cnt == 4'd14)
                  state <= S_SFD;
               else
                  pre_cnt <= pre_cnt + 4'd1;
            end
            S_SFD: begin
               eth_mii_txd   <= 4'hD;
               eth_mii_tx_en <= 1'b1;
               phase         <= 1'b0;
               ifg_cnt       <= '0;
               if (cur_valid) begin
                  byte_reg  <= cur_data;
                  byte_last <= cur_last;
                  byte_cnt  <= 16'd1;
                  state     <= S_DATA;
               end else begin
                  byte_cnt <= '0;
                  tx_abort <= 1'b1;
                  state    <= S_IFG;
               end
            end
            S_DATA: begin
               eth_mii_tx_en <= 1'b1;
               ifg_cnt       <= '0;
               if (!phase) begin
                  eth_mii_txd <= byte_reg[3:0];
                  phase       <= 1'b1;
               end else begin
                  eth_mii_txd <= byte_reg[7:4];
                  if (byte_last) begin
                     state <= S_IFG;
                  end else if (!byte_room || !cur_valid) begin
                     tx_abort <= 1'b1;
                     state    <= S_IFG;
                  end else begin
                     byte_reg  <= cur_data;
                     byte_last <= cur_last;
                     byte_cnt  <= byte_cnt + 16'd1;
                     phase     <= 1'b0;
                  end
               end
            end
            S_IFG: begin
               eth_mii_txd   <= '0;
               eth_mii_tx_en <= 1'b0;
               if (ifg_cnt == IFG_LAST)
                  state <= S_IDLE;
               else
                  ifg_cnt <= ifg_cnt + 1'b1;
            end
            default: begin
               eth_mii_txd   <= '0;
               eth_mii_tx_en <= 1'b0;
               state         <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_eth_mii_tx_scheduler.sv
// Directed bench for eth_mii_tx_scheduler (NUM_REQ=4, IFG_NIBBLES=24, MAX_BYTES=4).
module tb_eth_mii_tx_scheduler;

   logic        clk = 1'b0;
   logic        rstn;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_last;
   logic [3:0]  req_ready;
   logic [3:0]  txd;
   logic        en;
   logic [1:0]  gid;
   logic        busy;
   logic        abort;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   eth_mii_tx_scheduler #(
      .NUM_REQ    (4),
      .IFG_NIBBLES(24),
      .MAX_BYTES  (4)
   ) dut (
      .eth_mac_clock(clk),
      .eth_mac_rstn (rstn),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_last     (req_last),
      .req_ready    (req_ready),
      .eth_mii_txd  (txd),
      .eth_mii_tx_en(en),
      .grant_id     (gid),
      .busy         (busy),
      .tx_abort     (abort)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   // Source models: byte lists, consumed on valid&ready handshakes
   logic [7:0] smem [4][16];
   int  slen  [4];
   int  sdrop [4];
   bit  slast [4];
   bit  sall  [4];
   int  sidx  [4];
   bit  shs   [4];
   bit  sact  [4];
   bit  sv;

   always @(negedge clk) begin
      for (int s = 0; s < 4; s++) begin
         if (shs[s]) sidx[s] = sidx[s] + 1;
         sv = sact[s] && (sidx[s] < slen[s]) && (sidx[s] < sdrop[s]);
         req_valid[s]       = sv;
         req_data[8*s +: 8] = sv ? smem[s][sidx[s]] : 8'h00;
         req_last[s]        = sv && (sall[s] || (slast[s] && sidx[s] == slen[s] - 1));
         shs[s]             = sv && req_ready[s];
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic arm(input int s, input int n, input bit lst, input bit all, input int drop);
      sidx[s]  = 0;
      shs[s]   = 1'b0;
      slen[s]  = n;
      slast[s] = lst;
      sall[s]  = all;
      sdrop[s] = drop;
      sact[s]  = 1'b1;
   endtask

   task automatic wait_rise(input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit && !ok; i++) begin
         tick();
         if (en === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic wait_idle(input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit && !ok; i++) begin
         tick();
         if (busy === 1'b0 && en === 1'b0) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      tick();
      tick();
      checks++; if (en !== 1'b0)      begin errors++; $display("FAIL reset_en: got %b expected 0", en); end
      checks++; if (txd !== 4'h0)     begin errors++; $display("FAIL reset_txd: got %h expected 0", txd); end
      checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
      checks++; if (abort !== 1'b0)   begin errors++; $display("FAIL reset_abort: got %b expected 0", abort); end
      checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (gid !== 2'd0)     begin errors++; $display("FAIL reset_grant: got %0d expected 0", gid); end
      rstn = 1'b1;
      tick();
   endtask

   task automatic test_single_frame();
      logic [3:0] exp_n [20];
      bit ok;
      for (int i = 0; i < 15; i++) exp_n[i] = 4'h5;
      exp_n[15] = 4'hD; exp_n[16] = 4'h5; exp_n[17] = 4'hA; exp_n[18] = 4'hC; exp_n[19] = 4'h3;
      smem[0][0] = 8'hA5; smem[0][1] = 8'h3C;
      arm(0, 2, 1'b1, 1'b0, 99);
      wait_rise(10, ok);
      checks++; if (!ok) begin errors++; $display("FAIL t1_rise: got timeout expected tx_en rise"); end
      checks++; if (gid !== 2'd0) begin errors++; $display("FAIL t1_grant: got %0d expected 0", gid); end
      for (int k = 0; k < 20; k++) begin
         if (k > 0) tick();
         checks++;
         if (en !== 1'b1 || txd !== exp_n[k])
            begin errors++; $display("FAIL t1_nibble%0d: got en=%b txd=%h expected en=1 txd=%h", k, en, txd, exp_n[k]); end
      end
      for (int k = 0; k < 24; k++) begin
         tick();
         checks++;
         if (en !== 1'b0 || txd !== 4'h0)
            begin errors++; $display("FAIL t1_ifg%0d: got en=%b txd=%h expected en=0 txd=0", k, en, txd); end
         if (k == 22) begin
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t1_busy_ifg: got %b expected 1", busy); end
         end
         if (k == 23) begin
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t1_busy_idle: got %b expected 0", busy); end
         end
      end
      sact[0] = 1'b0;
      wait_idle(100, ok);
   endtask

   task automatic test_round_robin();
      int rise_at [5];
      logic [1:0] exp_g [5];
      bit ok;
      exp_g[0] = 2'd0; exp_g[1] = 2'd1; exp_g[2] = 2'd2; exp_g[3] = 2'd3; exp_g[4] = 2'd0;
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      for (int s = 0; s < 4; s++) begin
         smem[s][0] = 8'h01 + 8'(16 * s);
         smem[s][1] = 8'h01 + 8'(16 * s);
      end
      arm(0, 2, 1'b1, 1'b1, 99);
      arm(1, 1, 1'b1, 1'b1, 99);
      arm(2, 1, 1'b1, 1'b1, 99);
      arm(3, 1, 1'b1, 1'b1, 99);
      for (int f = 0; f < 5; f++) begin
         wait_rise(60, ok);
         checks++; if (!ok) begin errors++; $display("FAIL t2_rise%0d: got timeout expected tx_en rise", f); end
         rise_at[f] = cyc;
         checks++; if (gid !== exp_g[f]) begin errors++; $display("FAIL t2_grant%0d: got %0d expected %0d", f, gid, exp_g[f]); end
         for (int k = 1; k < 18; k++) begin
            tick();
            if (k == 17) begin
               checks++;
               if (txd !== {2'b00, exp_g[f]})
                  begin errors++; $display("FAIL t2_hinib%0d: got %h expected %h", f, txd, exp_g[f]); end
            end
         end
      end
      for (int f = 1; f < 5; f++) begin
         checks++;
         if (rise_at[f] - rise_at[f-1] != 43)
            begin errors++; $display("FAIL t2_spacing%0d: got %0d expected 43", f, rise_at[f] - rise_at[f-1]); end
      end
      for (int s = 0; s < 4; s++) sact[s] = 1'b0;
      wait_idle(100, ok);
      checks++; if (!ok) begin errors++; $display("FAIL t2_idle: got timeout expected idle"); end
   endtask

   task automatic test_underrun();
      logic [3:0] exp_n [18];
      int aborts = 0;
      bit ok;
      for (int i = 0; i < 15; i++) exp_n[i] = 4'h5;
      exp_n[15] = 4'hD; exp_n[16] = 4'h1; exp_n[17] = 4'h1;
      smem[2][0] = 8'h11; smem[2][1] = 8'h22; smem[2][2] = 8'h33;
      smem[3][0] = 8'h44;
      arm(2, 3, 1'b1, 1'b0, 1);
      arm(3, 1, 1'b1, 1'b0, 99);
      wait_rise(10, ok);
      checks++; if (!ok) begin errors++; $display("FAIL t3_rise: got timeout expected tx_en rise"); end
      checks++; if (gid !== 2'd2) begin errors++; $display("FAIL t3_grant: got %0d expected 2", gid); end
      for (int k = 0; k < 44; k++) begin
         if (k > 0) tick();
         if (abort === 1'b1) aborts++;
         checks++;
         if (k < 18) begin
            if (en !== 1'b1 || txd !== exp_n[k])
               begin errors++; $display("FAIL t3_nibble%0d: got en=%b txd=%h expected en=1 txd=%h", k, en, txd, exp_n[k]); end
         end else if (k < 43) begin
            if (en !== 1'b0) begin errors++; $display("FAIL t3_gap%0d: got en=%b expected 0", k, en); end
         end else begin
            if (en !== 1'b1 || gid !== 2'd3)
               begin errors++; $display("FAIL t3_next: got en=%b grant=%0d expected en=1 grant=3", en, gid); end
         end
      end
      checks++; if (aborts != 1) begin errors++; $display("FAIL t3_abort_count: got %0d expected 1", aborts); end
      checks++; if (sidx[2] != 1) begin errors++; $display("FAIL t3_consumed: got %0d expected 1", sidx[2]); end
      for (int k = 1; k < 18; k++) begin
         tick();
         if (k >= 16) begin
            checks++;
            if (txd !== 4'h4) begin errors++; $display("FAIL t3_src3_nib%0d: got %h expected 4", k, txd); end
         end
      end
      sact[2] = 1'b0; sact[3] = 1'b0;
      wait_idle(100, ok);
   endtask

   task automatic test_overrun();
      logic [3:0] exp_n [24];
      int aborts = 0;
      bit ok;
      for (int i = 0; i < 15; i++) exp_n[i] = 4'h5;
      exp_n[15] = 4'hD;
      for (int b = 0; b < 4; b++) begin
         exp_n[16 + 2*b] = 4'(b + 1);
         exp_n[17 + 2*b] = 4'h0;
      end
      for (int b = 0; b < 6; b++) smem[1][b] = 8'(b + 1);
      arm(1, 6, 1'b0, 1'b0, 99);
      wait_rise(10, ok);
      checks++; if (!ok) begin errors++; $display("FAIL t4_rise: got timeout expected tx_en rise"); end
      checks++; if (gid !== 2'd1) begin errors++; $display("FAIL t4_grant: got %0d expected 1", gid); end
      for (int k = 0; k < 31; k++) begin
         if (k > 0) tick();
         if (abort === 1'b1) aborts++;
         checks++;
         if (k < 24) begin
            if (en !== 1'b1 || txd !== exp_n[k])
               begin errors++; $display("FAIL t4_nibble%0d: got en=%b txd=%h expected en=1 txd=%h", k, en, txd, exp_n[k]); end
         end else begin
            if (en !== 1'b0) begin errors++; $display("FAIL t4_gap%0d: got en=%b expected 0", k, en); end
         end
      end
      sact[1] = 1'b0;
      checks++; if (aborts != 1) begin errors++; $display("FAIL t4_abort_count: got %0d expected 1", aborts); end
      checks++; if (sidx[1] != 4) begin errors++; $display("FAIL t4_consumed: got %0d expected 4", sidx[1]); end
      wait_idle(100, ok);
   endtask

   task automatic test_max_exact();
      logic [3:0] exp_n [24];
      int aborts = 0;
      bit ok;
      for (int i = 0; i < 15; i++) exp_n[i] = 4'h5;
      exp_n[15] = 4'hD;
      exp_n[16] = 4'h1; exp_n[17] = 4'hA; exp_n[18] = 4'h2; exp_n[19] = 4'hB;
      exp_n[20] = 4'h3; exp_n[21] = 4'hC; exp_n[22] = 4'h4; exp_n[23] = 4'hD;
      smem[2][0] = 8'hA1; smem[2][1] = 8'hB2; smem[2][2] = 8'hC3; smem[2][3] = 8'hD4;
      arm(2, 4, 1'b1, 1'b0, 99);
      wait_rise(10, ok);
      checks++; if (!ok) begin errors++; $display("FAIL tx_rise: got timeout expected tx_en rise"); end
      for (int k = 0; k < 31; k++) begin
         if (k > 0) tick();
         if (abort === 1'b1) aborts++;
         checks++;
         if (k < 24) begin
            if (en !== 1'b1 || txd !== exp_n[k])
               begin errors++; $display("FAIL tx_nibble%0d: got en=%b txd=%h expected en=1 txd=%h", k, en, txd, exp_n[k]); end
         end else begin
            if (en !== 1'b0) begin errors++; $display("FAIL tx_gap%0d: got en=%b expected 0", k, en); end
         end
      end
      checks++; if (aborts != 0) begin errors++; $display("FAIL tx_abort_count: got %0d expected 0", aborts); end
      checks++; if (sidx[2] != 4) begin errors++; $display("FAIL tx_consumed: got %0d expected 4", sidx[2]); end
      sact[2] = 1'b0;
      wait_idle(100, ok);
   endtask

   task automatic test_single_byte();
      int rdy_cnt = 0;
      int rdy_k = -1;
      int aborts = 0;
      int stray = 0;
      bit ok;
      smem[3][0] = 8'hF0;
      arm(3, 1, 1'b1, 1'b0, 99);
      wait_rise(10, ok);
      checks++; if (!ok) begin errors++; $display("FAIL t6_rise: got timeout expected tx_en rise"); end
      checks++; if (gid !== 2'd3) begin errors++; $display("FAIL t6_grant: got %0d expected 3", gid); end
      for (int k = 0; k < 20; k++) begin
         if (k > 0) tick();
         if (abort === 1'b1) aborts++;
         if (req_ready[3] === 1'b1) begin rdy_cnt++; rdy_k = k; end
         if (req_ready[2:0] !== 3'b000) stray++;
         if (k == 15) begin
            checks++; if (txd !== 4'hD) begin errors++; $display("FAIL t6_sfd: got %h expected d", txd); end
         end
         if (k == 16) begin
            checks++; if (txd !== 4'h0) begin errors++; $display("FAIL t6_lo: got %h expected 0", txd); end
         end
         if (k == 17) begin
            checks++; if (txd !== 4'hF) begin errors++; $display("FAIL t6_hi: got %h expected f", txd); end
         end
         if (k == 18) begin
            checks++; if (en !== 1'b0) begin errors++; $display("FAIL t6_end: got en=%b expected 0", en); end
         end
      end
      checks++; if (rdy_cnt != 1) begin errors++; $display("FAIL t6_ready_count: got %0d expected 1", rdy_cnt); end
      checks++; if (rdy_k != 14) begin errors++; $display("FAIL t6_ready_cycle: got %0d expected 14", rdy_k); end
      checks++; if (stray != 0) begin errors++; $display("FAIL t6_ready_other: got %0d expected 0", stray); end
      checks++; if (aborts != 0) begin errors++; $display("FAIL t6_abort: got %0d expected 0", aborts); end
      sact[3] = 1'b0;
      wait_idle(100, ok);
   endtask

   task automatic test_reset_mid_frame();
      bit ok;
      smem[0][0] = 8'h12; smem[0][1] = 8'h34; smem[0][2] = 8'h56;
      arm(0, 3, 1'b1, 1'b0, 99);
      wait_rise(10, ok);
      checks++; if (!ok) begin errors++; $display("FAIL t5_rise: got timeout expected tx_en rise"); end
      for (int k = 1; k < 18; k++) tick();
      rstn = 1'b0;
      #2;
      checks++;
      if (en !== 1'b0 || txd !== 4'h0 || busy !== 1'b0 || req_ready !== 4'h0 || gid !== 2'd0)
         begin errors++; $display("FAIL t5_async: got en=%b txd=%h busy=%b ready=%b grant=%0d expected all 0", en, txd, busy, req_ready, gid); end
      for (int s = 0; s < 4; s++) sact[s] = 1'b0;
      tick();
      tick();
      rstn = 1'b1;
      smem[0][0] = 8'h77; smem[1][0] = 8'h88; smem[3][0] = 8'h99;
      arm(0, 1, 1'b1, 1'b0, 99);
      arm(1, 1, 1'b1, 1'b0, 99);
      arm(3, 1, 1'b1, 1'b0, 99);
      wait_rise(10, ok);
      checks++; if (!ok) begin errors++; $display("FAIL t5_rise2: got timeout expected tx_en rise"); end
      checks++; if (gid !== 2'd0) begin errors++; $display("FAIL t5_grant: got %0d expected 0", gid); end
   endtask

   initial begin
      rstn      = 1'b0;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      for (int s = 0; s < 4; s++) begin
         sact[s] = 1'b0; sidx[s] = 0; shs[s] = 1'b0;
         slen[s] = 0; sdrop[s] = 0; slast[s] = 1'b0; sall[s] = 1'b0;
      end
      test_reset();
      test_single_frame();
      test_round_robin();
      test_underrun();
      test_overrun();
      test_max_exact();
      test_single_byte();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
